// File: rtl/irq_status_pkg.sv
// irq_status_pkg: register offsets, source indices and default source count for irq_status_ctrl
package irq_status_pkg;
  localparam int N_SRC_DEFAULT = 4;
  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_MODE = 3'd2;
  localparam logic [2:0] REG_RAW = 3'd3;
  localparam logic [2:0] REG_FIQSEL = 3'd4;
  localparam int SRC_ECONET = 0;
  localparam int SRC_IDE = 1;
  localparam int SRC_UART = 2;
  localparam int SRC_ETHERNET = 3;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: SYNC_STAGES-deep single-bit synchroniser with synchronous active-low reset
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= !rst_n ? '0 : {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/irq_status_ctrl.sv
// irq_status_ctrl: synchronise, latch (level/edge) and mask interrupt sources into irq; IRQ_FIQ_ROUTE_EN adds FIQSEL and fiq
module irq_status_ctrl
  import irq_status_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic [2:0]       a,
  input  logic [7:0]       d_in,
  output logic [7:0]       d_out,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq,
  output logic             fiq
);
  logic [N_SRC-1:0] sync, prev, pend, mask, mode, fiqsel, wd, chg, clr, rise, pend_nxt;
  logic we, re;
  logic [7:0] rdata;
  logic unused_d;
  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(irq_src[i]), .q(sync[i]));
  end
  assign unused_d = ^d_in;
  always_comb begin
    we = cs & wr;
    re = cs & rd & ~wr;
    wd = d_in[N_SRC-1:0];
    chg = (we && a == REG_MODE) ? wd ^ mode : '0;
    clr = (we && a == REG_PEND) ? wd : '0;
    rise = sync & ~prev;
    pend_nxt = ~chg & ((mode & (rise | (pend & ~clr))) | (~mode & sync));
    rdata = a == REG_PEND ? 8'(pend) :
            a == REG_MASK ? 8'(mask) :
            a == REG_MODE ? 8'(mode) :
            a == REG_RAW ? 8'(sync) :
            a == REG_FIQSEL ? 8'(fiqsel) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
      pend <= '0;
      mask <= '0;
      mode <= '0;
      d_out <= '0;
      irq <= 1'b0;
      fiq <= 1'b0;
    end else begin
      prev <= sync;
      pend <= pend_nxt;
      mask <= (we && a == REG_MASK) ? wd : mask;
      mode <= (we && a == REG_MODE) ? wd : mode;
      d_out <= re ? rdata : d_out;
      irq <= |(pend & mask & ~fiqsel);
      fiq <= |(pend & mask & fiqsel);
    end
  end
`ifdef IRQ_FIQ_ROUTE_EN
  always_ff @(posedge clk) fiqsel <= !rst_n ? '0 : (we && a == REG_FIQSEL) ? wd : fiqsel;
`else
  assign fiqsel = '0;
`endif
endmodule

// File: tb/tb_irq_status_ctrl.sv
// tb_irq_status_ctrl: directed and randomized checks of irq_status_ctrl against a cycle-level reference model
module tb_irq_status_ctrl;
  localparam int N = 4;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0;
  logic rd = 1'b0;
  logic wr = 1'b0;
  logic [2:0] a = '0;
  logic [7:0] d_in = '0;
  logic [N-1:0] irq_src = '0;
  logic [7:0] d_out;
  logic irq, fiq;
  logic [N-1:0] src = '0;
  int total = 0;
  int bad = 0;
  logic [N-1:0] m_hist [S];
  logic [N-1:0] m_prev = '0, m_pend = '0, m_mask = '0, m_mode = '0, m_fsel = '0;
  logic [7:0] m_dout = '0;
  logic m_irq = 1'b0, m_fiq = 1'b0;

  irq_status_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .a(a), .d_in(d_in),
    .d_out(d_out), .irq_src(irq_src), .irq(irq), .fiq(fiq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] sy, np;
    logic [7:0] rv;
    bit w, r;
    sy = m_hist[S-1];
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_hist[k] = '0;
      m_prev = '0; m_pend = '0; m_mask = '0; m_mode = '0; m_fsel = '0;
      m_dout = '0; m_irq = 0; m_fiq = 0;
      return;
    end
    w = cs && wr;
    r = cs && rd && !wr;
    rv = 8'h00;
    if (a == 3'd0) rv = 8'(m_pend);
    if (a == 3'd1) rv = 8'(m_mask);
    if (a == 3'd2) rv = 8'(m_mode);
    if (a == 3'd3) rv = 8'(sy);
`ifdef IRQ_FIQ_ROUTE_EN
    if (a == 3'd4) rv = 8'(m_fsel);
`endif
    m_irq = 0;
    m_fiq = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i]) begin
        if (m_fsel[i]) m_fiq = 1;
        else m_irq = 1;
      end
    if (r) m_dout = rv;
    for (int i = 0; i < N; i++) begin
      if (w && a == 3'd2 && d_in[i] != m_mode[i]) np[i] = 0;
      else if (m_mode[i]) np[i] = (sy[i] && !m_prev[i]) || (m_pend[i] && !(w && a == 3'd0 && d_in[i]));
      else np[i] = sy[i];
    end
    m_pend = np;
    m_prev = sy;
    for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq_src;
    if (w && a == 3'd1) m_mask = d_in[N-1:0];
    if (w && a == 3'd2) m_mode = d_in[N-1:0];
`ifdef IRQ_FIQ_ROUTE_EN
    if (w && a == 3'd4) m_fsel = d_in[N-1:0];
`endif
  endtask

  task automatic cyc(input bit c, input bit r, input bit w, input logic [2:0] ad, input logic [7:0] dd);
    cs = c; rd = r; wr = w; a = ad; d_in = dd; irq_src = src;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("irq", 8'(irq), 8'(m_irq));
    chk("fiq", 8'(fiq), 8'(m_fiq));
    chk("d_out", d_out, m_dout);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic wreg(input logic [2:0] ad, input logic [7:0] dd);
    cyc(1, 0, 1, ad, dd);
  endtask

  task automatic rreg(input logic [2:0] ad);
    cyc(1, 1, 0, ad, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < S; k++) m_hist[k] = '0;
    rst_n = 0;
    src = '1;
    idle(3);
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_fiq", 8'(fiq), 8'h00);
    chk("rst_dout", d_out, 8'h00);
    rst_n = 1;
    src = '0;
    rreg(3'd1); chk("rst_mask", d_out, 8'h00);
    rreg(3'd2); chk("rst_mode", d_out, 8'h00);
    rreg(3'd0); chk("rst_pend", d_out, 8'h00);

    wreg(3'd1, 8'h04);
    src = 4'h4;
    idle(3); chk("lvl_irq_e3", 8'(irq), 8'h00);
    idle(1); chk("lvl_irq_e4", 8'(irq), 8'h01);
    wreg(3'd0, 8'h04); chk("lvl_w1c_irq", 8'(irq), 8'h01);
    rreg(3'd0); chk("lvl_w1c_pend", d_out, 8'h04);
    src = 4'h0;
    idle(3); chk("lvl_drop_e3", 8'(irq), 8'h01);
    idle(1); chk("lvl_drop_e4", 8'(irq), 8'h00);

    wreg(3'd2, 8'h08);
    wreg(3'd1, 8'h08);
    src = 4'h8;
    idle(3);
    src = 4'h0;
    idle(4); chk("edge_irq_held", 8'(irq), 8'h01);
    rreg(3'd0); chk("edge_pend_rd", d_out, 8'h08); chk("edge_rd_irq", 8'(irq), 8'h01);
    wreg(3'd0, 8'h08); chk("edge_clr_k", 8'(irq), 8'h01);
    idle(1); chk("edge_clr_k1", 8'(irq), 8'h00);

    src = 4'h8;
    idle(2);
    wreg(3'd0, 8'h08);
    src = 4'h0;
    rreg(3'd0); chk("setclr_pend", d_out, 8'h08);
    idle(1); chk("setclr_irq", 8'(irq), 8'h01);

    src = 4'hF;
    wreg(3'd1, 8'h00);
    wreg(3'd2, 8'h00);
    idle(4); chk("mask0_irq", 8'(irq), 8'h00);
    rreg(3'd0); chk("all_pend", d_out, 8'h0F);
    wreg(3'd1, 8'h01); chk("mask1_k", 8'(irq), 8'h00);
    idle(1); chk("mask1_k1", 8'(irq), 8'h01);

    src = 4'h0;
    wreg(3'd2, 8'h02);
    idle(4);
    src = 4'h2;
    idle(4);
    rreg(3'd0); chk("ide_edge_pend", d_out, 8'h02);
    wreg(3'd2, 8'h00);
    rreg(3'd0); chk("mode_chg_clr", d_out, 8'h00);
    rreg(3'd0); chk("mode_reload", d_out, 8'h02);

    rreg(3'd7); chk("off7", d_out, 8'h00);
    cyc(1, 1, 1, 3'd1, 8'h05); chk("rdwr_hold", d_out, 8'h00);
    rreg(3'd1); chk("rdwr_write", d_out, 8'h05);
    rreg(3'd3); chk("raw", d_out, 8'h02);

`ifdef IRQ_FIQ_ROUTE_EN
    src = 4'h0;
    idle(4);
    wreg(3'd4, 8'h01);
    wreg(3'd1, 8'h03);
    rreg(3'd4); chk("fiqsel_rd", d_out, 8'h01);
    src = 4'h3;
    idle(5); chk("route_fiq", 8'(fiq), 8'h01); chk("route_irq", 8'(irq), 8'h01);
    src = 4'h1;
    idle(5); chk("ide_clr_fiq", 8'(fiq), 8'h01); chk("ide_clr_irq", 8'(irq), 8'h00);
`else
    wreg(3'd4, 8'h01);
    rreg(3'd4); chk("off4", d_out, 8'h00);
    src = 4'h1;
    wreg(3'd1, 8'h01);
    idle(5); chk("nofiq", 8'(fiq), 8'h00); chk("nofiq_irq", 8'(irq), 8'h01);
`endif

    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) src = N'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
          3'($urandom_range(0, 7)), 8'($urandom));
    end
    rst_n = 1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
